// File: rtl/si3000_wb_sequencer.sv
// si3000_wb_sequencer: bus master that brings up the Si3000 codec wrapper
// (MCLK on, codec reset pulse, datapath sync), loads a table of control words
// through mode-0 secondary frames, then streams samples both ways.
// Ports: clk/reset_n (sync, active low); start/stop pulses; cfg_table words;
//   tx_data/tx_valid/tx_ready sample source; rx_data/rx_valid sample sink;
//   stb_o/we_o/adr_wr_o/adr_rd_o/dat_o/dat_i/ack_i single-cycle register bus;
//   running/error/cfg_index status.
module si3000_wb_sequencer #(
   parameter int DATA_WIDTH               = 8,
   parameter int REG_ADDR_WRITE_DATA_LOW  = 0,
   parameter int REG_ADDR_WRITE_DATA_HIGH = 1,
   parameter int REG_ADDR_READ_DATA_LOW   = 2,
   parameter int REG_ADDR_READ_DATA_HIGH  = 3,
   parameter int REG_ADDR_CSR             = 4,
   parameter int NUM_CFG                  = 4,
   parameter int RESET_CYCLES             = 1024,
   parameter int TIMEOUT_CYCLES           = 65535
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [16*NUM_CFG-1:0] cfg_table,
   input  logic [15:0]           tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [15:0]           rx_data,
   output logic                  rx_valid,
   output logic                  stb_o,
   output logic                  we_o,
   output logic [DATA_WIDTH-1:0] adr_wr_o,
   output logic [DATA_WIDTH-1:0] adr_rd_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   input  logic                  ack_i,
   output logic                  running,
   output logic                  error,
   output logic [3:0]            cfg_index
);

   localparam logic [DATA_WIDTH-1:0] A_WLO = DATA_WIDTH'(REG_ADDR_WRITE_DATA_LOW);
   localparam logic [DATA_WIDTH-1:0] A_WHI = DATA_WIDTH'(REG_ADDR_WRITE_DATA_HIGH);
   localparam logic [DATA_WIDTH-1:0] A_RLO = DATA_WIDTH'(REG_ADDR_READ_DATA_LOW);
   localparam logic [DATA_WIDTH-1:0] A_RHI = DATA_WIDTH'(REG_ADDR_READ_DATA_HIGH);
   localparam logic [DATA_WIDTH-1:0] A_CSR = DATA_WIDTH'(REG_ADDR_CSR);
   localparam logic [15:0] RST_LOAD = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  LAST_CFG = 4'(NUM_CFG - 1);

   typedef enum logic [4:0] {
      S_IDLE,
      S_EN,
      S_RST_HOLD,
      S_RST_REL,
      S_SYNC,
      S_CFG_PRI_HI,
      S_CFG_PRI_LO,
      S_CFG_WAIT1,
      S_CFG_SEC_HI,
      S_CFG_SEC_LO,
      S_CFG_WAIT2,
      S_RUN_POLL,
      S_RUN_WR_HI,
      S_RUN_WR_LO,
      S_RUN_RD_HI,
      S_RUN_RD_LO,
      S_STOP,
      S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] txl_q, txl_d;
   logic [7:0]  rxh_q, rxh_d;
   logic [15:0] rxd_q, rxd_d;
   logic        rxv_q, rxv_d;
   logic        err_q, err_d;
   logic [7:0]  wbyte;
   logic [15:0] cfg_word;
   logic        wr_busy;
   logic        data_avail;
   logic        stop_hit;

   assign wr_busy    = dat_i[2];
   assign data_avail = dat_i[3];
   assign dat_o      = DATA_WIDTH'(wbyte);
   assign rx_data    = rxd_q;
   assign rx_valid   = rxv_q;
   assign error      = err_q;
   assign cfg_index  = idx_q;
   assign running    = state_q inside {S_RUN_POLL, S_RUN_WR_HI, S_RUN_WR_LO,
                                       S_RUN_RD_HI, S_RUN_RD_LO};
   assign stop_hit   = stop && (state_q != S_IDLE) && (state_q != S_STOP);

   always_comb begin
      cfg_word = 16'h0000;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (idx_q == 4'(i)) cfg_word = cfg_table[16*i +: 16];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      txl_d    = txl_q;
      rxh_d    = rxh_q;
      rxd_d    = rxd_q;
      rxv_d    = 1'b0;
      err_d    = err_q;
      stb_o    = 1'b0;
      we_o     = 1'b0;
      adr_wr_o = '0;
      adr_rd_o = '0;
      wbyte    = 8'h00;
      tx_ready = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               err_d   = 1'b0;
               state_d = S_EN;
            end
         end
         S_EN: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_CSR; wbyte = 8'h02;
            if (ack_i) begin
               cnt_d   = RST_LOAD;
               state_d = S_RST_HOLD;
            end
         end
         S_RST_HOLD: begin
            // Leaving as the count hits 0 keeps RESET_N low for exactly
            // RESET_CYCLES clocks between the two CSR writes.
            if (cnt_q <= 16'd1) begin
               cnt_d   = 16'd0;
               state_d = S_RST_REL;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_RST_REL: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_CSR; wbyte = 8'h82;
            if (ack_i) state_d = S_SYNC;
         end
         S_SYNC: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_CSR; wbyte = 8'h83;
            if (ack_i) begin
               idx_d   = 4'd0;
               state_d = S_CFG_PRI_HI;
            end
         end
         S_CFG_PRI_HI: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_WHI; wbyte = 8'h00;
            if (ack_i) state_d = S_CFG_PRI_LO;
         end
         S_CFG_PRI_LO: begin
            // LSB set asks the codec for a secondary frame.
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_WLO; wbyte = 8'h01;
            if (ack_i) begin
               cnt_d   = 16'd0;
               state_d = S_CFG_WAIT1;
            end
         end
         S_CFG_WAIT1: begin
            stb_o = 1'b1; adr_rd_o = A_CSR;
            if (ack_i && !wr_busy) begin
               state_d = S_CFG_SEC_HI;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_CFG_SEC_HI: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_WHI;
            wbyte = cfg_word[15:8];
            if (ack_i) state_d = S_CFG_SEC_LO;
         end
         S_CFG_SEC_LO: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_WLO;
            wbyte = cfg_word[7:0];
            if (ack_i) begin
               cnt_d   = 16'd0;
               state_d = S_CFG_WAIT2;
            end
         end
         S_CFG_WAIT2: begin
            stb_o = 1'b1; adr_rd_o = A_CSR;
            if (ack_i && !wr_busy) begin
               if (idx_q == LAST_CFG) begin
                  state_d = S_RUN_POLL;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_CFG_PRI_HI;
               end
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RUN_POLL: begin
            stb_o = 1'b1; adr_rd_o = A_CSR;
            if (ack_i) begin
               if (data_avail) begin
                  state_d = S_RUN_RD_HI;
               end else if (!wr_busy && tx_valid && !stop) begin
                  // LSB cleared so a sample never requests a secondary frame.
                  tx_ready = 1'b1;
                  txl_d    = {tx_data[15:1], 1'b0};
                  state_d  = S_RUN_WR_HI;
               end
            end
         end
         S_RUN_WR_HI: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_WHI;
            wbyte = txl_q[15:8];
            if (ack_i) state_d = S_RUN_WR_LO;
         end
         S_RUN_WR_LO: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_WLO;
            wbyte = txl_q[7:0];
            if (ack_i) state_d = S_RUN_POLL;
         end
         S_RUN_RD_HI: begin
            stb_o = 1'b1; adr_rd_o = A_RHI;
            if (ack_i) begin
               rxh_d   = dat_i[7:0];
               state_d = S_RUN_RD_LO;
            end
         end
         S_RUN_RD_LO: begin
            stb_o = 1'b1; adr_rd_o = A_RLO;
            if (ack_i) begin
               rxd_d   = {rxh_q, dat_i[7:0]};
               rxv_d   = 1'b1;
               state_d = S_RUN_POLL;
            end
         end
         S_STOP: begin
            stb_o = 1'b1; we_o = 1'b1; adr_wr_o = A_CSR; wbyte = 8'h00;
            if (ack_i) state_d = S_IDLE;
         end
         S_ERROR: begin
            if (start && !stop) begin
               err_d   = 1'b0;
               state_d = S_EN;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The access of this cycle (if acked) still completes; only the
      // successor changes to the shutdown write.
      if (stop_hit) state_d = S_STOP;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 4'd0;
         txl_q   <= 16'd0;
         rxh_q   <= 8'd0;
         rxd_q   <= 16'd0;
         rxv_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         txl_q   <= txl_d;
         rxh_q   <= rxh_d;
         rxd_q   <= rxd_d;
         rxv_q   <= rxv_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_si3000_wb_sequencer.sv
// Directed bench for si3000_wb_sequencer with a small codec-wrapper model:
// write log, wr_busy timer, data_avail flag and read-data registers.
module tb_si3000_wb_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, start, stop;
   logic [31:0] cfg_table = {16'h0240, 16'h0105};
   logic [15:0] tx_data;
   logic        tx_valid, tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid, stb_o, we_o, ack_i, running, error;
   logic [7:0]  adr_wr_o, adr_rd_o, dat_o, dat_i;
   logic [3:0]  cfg_index;

   logic [16:0] acc[$];
   int          csr_cyc[$];
   int          cyc = 0;
   int          bcnt = 0;
   logic        avail = 1'b0;
   logic        avail_req, force_busy, busy;
   logic [7:0]  rd_hi, rd_lo;
   int          csr_reads = 0, tx_acc = 0, rx_cnt = 0, bad_ready = 0;
   logic [15:0] rx_last = 16'h0;

   int n_chk = 0, n_fail = 0;
   int b, c0, t0, r0, p0;

   logic [16:0] exp_up [11] = '{17'h10402, 17'h10482, 17'h10483,
                               17'h10100, 17'h10001, 17'h10101, 17'h10005,
                               17'h10100, 17'h10001, 17'h10102, 17'h10040};

   always #5 clk = ~clk;

   si3000_wb_sequencer #(
      .NUM_CFG(2), .RESET_CYCLES(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .cfg_table(cfg_table), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .stb_o(stb_o), .we_o(we_o), .adr_wr_o(adr_wr_o), .adr_rd_o(adr_rd_o),
      .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .running(running),
      .error(error), .cfg_index(cfg_index)
   );

   assign ack_i = stb_o;
   assign busy  = (bcnt != 0) || force_busy;

   always_comb begin
      dat_i = 8'h00;
      if (adr_rd_o == 8'd4)      dat_i = {4'b0000, avail, busy, 2'b00};
      else if (adr_rd_o == 8'd3) dat_i = rd_hi;
      else if (adr_rd_o == 8'd2) dat_i = rd_lo;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_ready) tx_acc <= tx_acc + 1;
      if (tx_ready && !tx_valid) bad_ready <= bad_ready + 1;
      if (rx_valid) begin
         rx_cnt  <= rx_cnt + 1;
         rx_last <= rx_data;
      end
      if (stb_o && ack_i && we_o) begin
         acc.push_back({1'b1, adr_wr_o, dat_o});
         if (adr_wr_o == 8'd4) csr_cyc.push_back(cyc);
      end
      if (stb_o && ack_i && we_o && adr_wr_o == 8'd0) bcnt <= 5;
      else if (bcnt != 0) bcnt <= bcnt - 1;
      if (stb_o && ack_i && !we_o) begin
         if (adr_rd_o == 8'd4) csr_reads <= csr_reads + 1;
         else acc.push_back({1'b0, adr_rd_o, dat_i});
         if (adr_rd_o == 8'd2) avail <= 1'b0;
      end
      if (avail_req) avail <= 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 0; start = 0; stop = 0; tx_data = 0; tx_valid = 0;
      avail_req = 0; force_busy = 0; rd_hi = 0; rd_lo = 0;
      repeat (3) step();
      chk("rst_stb", stb_o, 0);
      chk("rst_we", we_o, 0);
      chk("rst_adr_wr", adr_wr_o, 0);
      chk("rst_adr_rd", adr_rd_o, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_running", running, 0);
      chk("rst_error", error, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_cfg_index", cfg_index, 0);
      reset_n = 1;
      step();

      // bring-up
      b = acc.size(); c0 = csr_cyc.size();
      start = 1; step(); start = 0;
      for (int k = 0; k < 300 && acc.size() < b + 11; k++) step();
      chk("up_len", acc.size() - b, 11);
      for (int i = 0; i < 11; i++)
         chk($sformatf("up%0d", i), acc[b+i], exp_up[i]);
      chk("rst_gap", csr_cyc[c0+1] - csr_cyc[c0], 8);
      repeat (8) step();
      chk("up_running", running, 1);
      chk("up_cfg_index", cfg_index, 1);
      chk("up_no_tx", tx_acc, 0);

      // TX stream
      t0 = tx_acc; b = acc.size();
      tx_data = 16'hABCD; tx_valid = 1; #1;
      chk("tx_ready_now", tx_ready, 1);
      for (int k = 0; k < 50 && tx_acc == t0; k++) step();
      tx_valid = 0;
      for (int k = 0; k < 50 && acc.size() < b + 2; k++) step();
      chk("tx_hi", acc[b], 17'h101AB);
      chk("tx_lo", acc[b+1], 17'h100CC);
      repeat (10) step();
      chk("tx_once", tx_acc - t0, 1);

      // RX stream
      rd_hi = 8'h12; rd_lo = 8'h34; r0 = rx_cnt; b = acc.size();
      avail_req = 1; step(); avail_req = 0;
      for (int k = 0; k < 50 && rx_cnt == r0; k++) step();
      chk("rx_data", rx_last, 16'h1234);
      chk("rx_rd_hi", acc[b], 17'h00312);
      chk("rx_rd_lo", acc[b+1], 17'h00234);
      repeat (5) step();
      chk("rx_once", rx_cnt - r0, 1);

      // simultaneous RX and TX
      rd_hi = 8'h56; rd_lo = 8'h78;
      r0 = rx_cnt; t0 = tx_acc; b = acc.size();
      avail_req = 1; step(); avail_req = 0;
      tx_data = 16'h1357; tx_valid = 1;
      for (int k = 0; k < 50 && tx_acc == t0; k++) step();
      tx_valid = 0;
      for (int k = 0; k < 50 && acc.size() < b + 4; k++) step();
      chk("sim_rd_hi", acc[b], 17'h00356);
      chk("sim_rd_lo", acc[b+1], 17'h00278);
      chk("sim_wr_hi", acc[b+2], 17'h10113);
      chk("sim_wr_lo", acc[b+3], 17'h10056);
      chk("sim_rx", rx_last, 16'h5678);
      chk("sim_tx_cnt", tx_acc - t0, 1);

      // stop during RUN_WR_HI
      repeat (8) step();
      t0 = tx_acc; b = acc.size();
      tx_data = 16'h2468; tx_valid = 1;
      for (int k = 0; k < 50 && tx_acc == t0; k++) step();
      tx_valid = 0; stop = 1;
      step();
      stop = 0;
      chk("stop_adr", adr_wr_o, 4);
      chk("stop_dat", dat_o, 0);
      step();
      chk("stop_running", running, 0);
      chk("stop_stb", stb_o, 0);
      chk("stop_tx_ready", tx_ready, 0);
      chk("stop_len", acc.size() - b, 2);
      chk("stop_hi", acc[b], 17'h10124);
      chk("stop_csr", acc[b+1], 17'h10400);

      // timeout in CFG_WAIT1
      b = acc.size(); p0 = csr_reads;
      force_busy = 1; start = 1; step(); start = 0;
      for (int k = 0; k < 200 && error !== 1'b1; k++) step();
      chk("to_error", error, 1);
      chk("to_polls", csr_reads - p0, 16);
      chk("to_len", acc.size() - b, 5);
      step();
      chk("to_stb", stb_o, 0);

      // restart from ERROR
      force_busy = 0; b = acc.size();
      start = 1; step(); start = 0;
      chk("re_error", error, 0);
      chk("re_stb", stb_o, 1);
      chk("re_adr", adr_wr_o, 4);
      chk("re_dat", dat_o, 8'h02);

      // reset mid-CFG
      for (int k = 0; k < 200 && acc.size() < b + 9; k++) step();
      chk("mid_cfg_index", cfg_index, 1);
      chk("mid_stb", stb_o, 1);
      reset_n = 0; step();
      chk("mr_stb", stb_o, 0);
      chk("mr_adr_rd", adr_rd_o, 0);
      chk("mr_cfg_index", cfg_index, 0);
      chk("mr_running", running, 0);
      chk("mr_error", error, 0);
      reset_n = 1; step();

      chk("ready_implies_valid", bad_ready, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
